fft_peak_finder: RTL and testbench

FFT_PEAK_FINDER -- requirements
Module: fft_peak_finder

---
 rtl/fft_peak_finder.sv | 202 ++++++++++++++++++++
 tb/tb_fft_peak_finder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_finder.sv
// fft_peak_finder
//
// Finds the largest-magnitude bin in each frame of FFT output. Magnitude is
// |re| + |im|. Only bins 1..N/2-1 are candidates; DC and the mirrored upper
// half are skipped. Ties resolve to the lowest bin index. One report is issued
// per complete frame, three cycles after bin N/2-1 is accepted.
//
// Optional feature, macro FFT_PEAK_THRESH_EN: if the winning magnitude is
// below MIN_MAG, the report carries bin 0 / magnitude 0 (no pitch).
// Without the macro, the raw winner is reported.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-low reset
//   in_valid    FFT sample present this cycle
//   in_sop      with in_valid, marks bin 0 of a frame
//   in_real     signed real part, DATA_W bits
//   in_imag     signed imaginary part, DATA_W bits
//   peak_bin    index of the winning bin, N_LOG2-1 bits
//   peak_mag    unsigned magnitude of the winner, DATA_W+1 bits
//   peak_valid  one-cycle pulse: new peak_bin/peak_mag
//   frame_err   one-cycle pulse: in_sop arrived mid-frame
module fft_peak_finder #(
  parameter int DATA_W  = 18,
  parameter int N_LOG2  = 10,
  parameter int MIN_MAG = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     in_sop,
  input  logic signed [DATA_W-1:0] in_real,
  input  logic signed [DATA_W-1:0] in_imag,
  output logic [N_LOG2-2:0]        peak_bin,
  output logic [DATA_W:0]          peak_mag,
  output logic                     peak_valid,
  output logic                     frame_err
);

  localparam logic [N_LOG2-1:0] LAST_BIN  = '1;
  localparam logic [N_LOG2-1:0] HALF_LAST = {1'b0, {(N_LOG2-1){1'b1}}};
  localparam logic [N_LOG2-1:0] BIN_ONE   = N_LOG2'(1);
  localparam logic [DATA_W:0]   MIN_MAG_C = (DATA_W+1)'(MIN_MAG);

`ifdef FFT_PEAK_THRESH_EN
  localparam bit THRESH_EN = 1'b1;
`else
  localparam bit THRESH_EN = 1'b0;
`endif

  // Absolute value as an unsigned DATA_W-bit result, so the most negative
  // input maps exactly to 2^(DATA_W-1) without saturation.
  function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] x);
    logic [DATA_W-1:0] ux;
    ux = x;
    return x[DATA_W-1] ? (~ux + DATA_W'(1)) : ux;
  endfunction

  function automatic logic [DATA_W:0] mag_sum(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  typedef enum logic {WAIT_SOP = 1'b0, ACCUM = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [N_LOG2-1:0]  cnt_q, cnt_d;
  logic               accept;
  logic               kill;
  logic [N_LOG2-1:0]  in_bin;

  logic [DATA_W-1:0]  abs_re_p0_q, abs_re_p0_d;
  logic [DATA_W-1:0]  abs_im_p0_q, abs_im_p0_d;
  logic [N_LOG2-1:0]  bin_p0_q, bin_p0_d;
  logic               vld_p0_q, vld_p0_d;

  logic [DATA_W:0]    mag_p1_q, mag_p1_d;
  logic [N_LOG2-1:0]  bin_p1_q, bin_p1_d;
  logic               vld_p1_q, vld_p1_d;

  logic [DATA_W:0]    cand_mag_q, cand_mag_d;
  logic [N_LOG2-2:0]  cand_bin_q, cand_bin_d;
  logic [N_LOG2-2:0]  peak_bin_q, peak_bin_d;
  logic [DATA_W:0]    peak_mag_q, peak_mag_d;
  logic               peak_valid_q, peak_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               take;
  logic               is_cand;

  // Input side: frame FSM and bin counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    kill    = 1'b0;
    in_bin  = cnt_q;
    if (in_valid) begin
      if (in_sop) begin
        accept  = 1'b1;
        in_bin  = '0;
        kill    = (state_q == ACCUM) && (cnt_q != '0);
        state_d = ACCUM;
        cnt_d   = BIN_ONE;
      end else if (state_q == ACCUM) begin
        accept = 1'b1;
        if (cnt_q == LAST_BIN) begin
          state_d = WAIT_SOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + BIN_ONE;
        end
      end
    end
  end

  // Stage 1: absolute values and bin index
  always_comb begin
    abs_re_p0_d = abs_val(in_real);
    abs_im_p0_d = abs_val(in_imag);
    bin_p0_d    = in_bin;
    vld_p0_d    = accept;
  end

  // Stage 2: magnitude sum; a mid-frame restart flushes the older sample
  always_comb begin
    mag_p1_d = mag_sum(abs_re_p0_q, abs_im_p0_q);
    bin_p1_d = bin_p0_q;
    vld_p1_d = vld_p0_q && !kill;
  end

  // Stage 3: compare/update candidate and issue the frame report
  always_comb begin
    take         = vld_p1_q && !kill;
    is_cand      = (bin_p1_q != '0) && !bin_p1_q[N_LOG2-1];
    cand_mag_d   = cand_mag_q;
    cand_bin_d   = cand_bin_q;
    peak_bin_d   = peak_bin_q;
    peak_mag_d   = peak_mag_q;
    peak_valid_d = 1'b0;
    frame_err_d  = kill;
    if (kill) begin
      cand_mag_d = '0;
      cand_bin_d = '0;
    end else if (take && is_cand) begin
      // Bin 1 seeds the search; strict compare keeps the lowest bin on ties.
      if ((bin_p1_q == BIN_ONE) || (mag_p1_q > cand_mag_q)) begin
        cand_mag_d = mag_p1_q;
        cand_bin_d = bin_p1_q[N_LOG2-2:0];
      end
      if (bin_p1_q == HALF_LAST) begin
        peak_valid_d = 1'b1;
        if (THRESH_EN && (cand_mag_d < MIN_MAG_C)) begin
          peak_bin_d = '0;
          peak_mag_d = '0;
        end else begin
          peak_bin_d = cand_bin_d;
          peak_mag_d = cand_mag_d;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= WAIT_SOP;
      cnt_q        <= '0;
      vld_p0_q     <= 1'b0;
      vld_p1_q     <= 1'b0;
      cand_mag_q   <= '0;
      cand_bin_q   <= '0;
      peak_bin_q   <= '0;
      peak_mag_q   <= '0;
      peak_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      vld_p0_q     <= vld_p0_d;
      vld_p1_q     <= vld_p1_d;
      cand_mag_q   <= cand_mag_d;
      cand_bin_q   <= cand_bin_d;
      peak_bin_q   <= peak_bin_d;
      peak_mag_q   <= peak_mag_d;
      peak_valid_q <= peak_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_ff @(posedge clk) begin
    abs_re_p0_q <= abs_re_p0_d;
    abs_im_p0_q <= abs_im_p0_d;
    bin_p0_q    <= bin_p0_d;
    mag_p1_q    <= mag_p1_d;
    bin_p1_q    <= bin_p1_d;
  end

  assign peak_bin   = peak_bin_q;
  assign peak_mag   = peak_mag_q;
  assign peak_valid = peak_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_fft_peak_finder.sv
// tb_fft_peak_finder
//
// Scoreboard bench for fft_peak_finder. The driver issues directed frames and
// pushes the hand-computed report (bin, magnitude, cycle) and any expected
// frame_err cycle into queues; an independent monitor compares on every
// peak_valid / frame_err and checks that outputs hold between reports.
// Honors FFT_PEAK_THRESH_EN for the no-pitch expectations.
module tb_fft_peak_finder;

  localparam int DATA_W = 18;
  localparam int N_LOG2 = 10;
  localparam int N      = 1024;
  localparam int HALF   = 512;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_sop = 1'b0;
  logic signed [DATA_W-1:0] in_real = '0;
  logic signed [DATA_W-1:0] in_imag = '0;
  logic [N_LOG2-2:0]        peak_bin;
  logic [DATA_W:0]          peak_mag;
  logic                     peak_valid;
  logic                     frame_err;

  fft_peak_finder #(.DATA_W(DATA_W), .N_LOG2(N_LOG2), .MIN_MAG(1000)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_sop     (in_sop),
    .in_real    (in_real),
    .in_imag    (in_imag),
    .peak_bin   (peak_bin),
    .peak_mag   (peak_mag),
    .peak_valid (peak_valid),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int bin;
    int mag;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   err_q[$];
  exp_t mon_e;
  int   mon_c;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;
  int   hold_bin = 0;
  int   hold_mag = 0;
  int   re_arr[N];
  int   im_arr[N];

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  function automatic int exp_bin_f(input int b, input int m);
`ifdef FFT_PEAK_THRESH_EN
    return (m < 1000) ? 0 : b;
`else
    return (m < 0) ? 0 : b;
`endif
  endfunction

  function automatic int exp_mag_f(input int m);
`ifdef FFT_PEAK_THRESH_EN
    return (m < 1000) ? 0 : m;
`else
    return m;
`endif
  endfunction

  // Monitor: compares DUT reports against the scoreboard queues.
  always @(negedge clk) begin
    if (mon_en) begin
      if (peak_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_report: actual bin=%0d mag=%0d at cycle %0d, required no report",
                   peak_bin, peak_mag, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("report_bin", int'(peak_bin), mon_e.bin);
          check("report_mag", int'(peak_mag), mon_e.mag);
          check("report_cycle", cyc, mon_e.cyc);
          hold_bin = mon_e.bin;
          hold_mag = mon_e.mag;
        end
      end else begin
        n_tests++;
        if ((int'(peak_bin) != hold_bin) || (int'(peak_mag) != hold_mag)) begin
          n_fail++;
          $display("FAIL hold: actual bin=%0d mag=%0d at cycle %0d, required bin=%0d mag=%0d",
                   peak_bin, peak_mag, cyc, hold_bin, hold_mag);
        end
      end
      if (frame_err) begin
        if (err_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_frame_err: actual pulse at cycle %0d, required none", cyc);
        end else begin
          mon_c = err_q.pop_front();
          check("frame_err_cycle", cyc, mon_c);
        end
      end
    end
  end

  task automatic clear_frame();
    for (int i = 0; i < N; i++) begin
      re_arr[i] = 0;
      im_arr[i] = 0;
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  // Sends bins 0..n_bins-1; if bin N/2-1 is sent, the report is expected
  // three cycles after it is accepted.
  task automatic send_frame(input int n_bins, input int gap_max,
                            input int exp_bin, input int exp_mag, input bit exp_err);
    exp_t e;
    int   g;
    for (int i = 0; i < n_bins; i++) begin
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (g) idle_cycle();
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_sop   = (i == 0);
      in_real  = DATA_W'(re_arr[i]);
      in_imag  = DATA_W'(im_arr[i]);
      if ((i == 0) && exp_err) err_q.push_back(cyc + 1);
      if (i == HALF - 1) begin
        e.bin = exp_bin_f(exp_bin, exp_mag);
        e.mag = exp_mag_f(exp_mag);
        e.cyc = cyc + 3;
        exp_q.push_back(e);
      end
    end
    idle_cycle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("reset_peak_bin", int'(peak_bin), 0);
    check("reset_peak_mag", int'(peak_mag), 0);
    check("reset_peak_valid", int'(peak_valid), 0);
    check("reset_frame_err", int'(frame_err), 0);
    mon_en = 1'b1;

    // Tone at bin 37: 5000 + 3000
    clear_frame();
    re_arr[37] = 5000;
    im_arr[37] = -3000;
    send_frame(N, 0, 37, 8000, 1'b0);

    // DC and mirror excluded; tie keeps the lower bin
    clear_frame();
    re_arr[0]   = 100000;
    re_arr[700] = 120000;
    re_arr[20]  = 1000;
    re_arr[40]  = 1000;
    send_frame(N, 0, 20, 1000, 1'b0);

    // Most negative components: 131072 + 131072
    clear_frame();
    re_arr[9] = -131072;
    im_arr[9] = -131072;
    send_frame(N, 0, 9, 262144, 1'b0);

    // All-zero frame: bin 1 seeds and wins
    clear_frame();
    send_frame(N, 0, 1, 0, 1'b0);

    // Premature sop at bin 300, then a full frame
    clear_frame();
    re_arr[100] = 7777;
    send_frame(300, 0, 0, 0, 1'b0);
    clear_frame();
    re_arr[12] = 50;
    send_frame(N, 0, 12, 50, 1'b1);

    // Reset low for one cycle at bin 200, then a new frame
    clear_frame();
    re_arr[50] = 9999;
    send_frame(200, 0, 0, 0, 1'b0);
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("midreset_peak_bin", int'(peak_bin), 0);
    check("midreset_peak_mag", int'(peak_mag), 0);
    check("midreset_peak_valid", int'(peak_valid), 0);
    hold_bin = 0;
    hold_mag = 0;
    mon_en = 1'b1;
    clear_frame();
    re_arr[77] = 4000;
    im_arr[77] = 321;
    send_frame(N, 0, 77, 4321, 1'b0);

    // Tone frame with random input gaps of 0-7 cycles
    clear_frame();
    re_arr[37] = 5000;
    im_arr[37] = -3000;
    send_frame(N, 7, 37, 8000, 1'b0);

    repeat (10) idle_cycle();
    @(negedge clk);
    check("pending_reports", exp_q.size(), 0);
    check("pending_frame_errs", err_q.size(), 0);
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
